// File: rtl/tdc_meas_sequencer.sv
// ----------------------------------------------------------------------------
// tdc_meas_sequencer
//   Sequences one TDC measurement shot: a start trigger opens the measure
//   window, then the stop-blanking window runs with the save strobe and the
//   TDC master reset, then the sequencer returns to idle. Shot timing comes
//   from run-time registers that can be written only while idle. Completed
//   shots are counted modulo the result FIFO depth.
//
//   Optional feature macro: STOP_CHAN_MASK_EN
//     defined   : cfg_addr 3 writes a per-channel stop_dis mask
//     undefined : mask fixed at 4'hF; a cfg_addr 3 write is silently ignored
//
// Ports
//   clk          clock, all logic on posedge
//   reset        synchronous active-high reset
//   cfg_we       config write strobe
//   cfg_addr     0=test_time 1=period 2=mrst_start 3=stop mask
//   cfg_wdata    config write data
//   tstart_tri   shot start trigger, level sampled every cycle
//   stop_dis     per-channel TDC stop disable (blanking window)
//   master_rst   TDC master reset pulse
//   data_save    one-cycle strobe: TDC results ready to store
//   busy         shot in progress
//   cfg_err      one-cycle strobe: rejected write or rejected trigger
//   shot_cnt     completed shots modulo FIFO_DEPTH
//   fifo_wrap    one-cycle strobe when shot_cnt wraps to 0
//   overrun_cnt  triggers ignored while busy, saturating
// ----------------------------------------------------------------------------
module tdc_meas_sequencer #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEF_TEST_TIME  = 15000,
    parameter int unsigned DEF_PERIOD     = 20000,
    parameter int unsigned DEF_MRST_START = 16000,
    parameter int unsigned MRST_LEN       = 30,
    parameter int unsigned SAVE_OFFSET    = 100,
    parameter int unsigned FIFO_DEPTH     = 8192
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             tstart_tri,
    output logic [3:0]       stop_dis,
    output logic             master_rst,
    output logic             data_save,
    output logic             busy,
    output logic             cfg_err,
    output logic [12:0]      shot_cnt,
    output logic             fifo_wrap,
    output logic [7:0]       overrun_cnt
);

    // One extra bit so offset sums never wrap in the compares.
    localparam int unsigned XW        = CNT_W + 1;
    localparam logic [12:0] SHOT_LAST = 13'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, MEAS, BLANK} state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] count, countNext;
    logic [CNT_W-1:0] testTime, period, mrstStart;
    logic [3:0]       mask;
    logic             shotDone, badTrig, cfgValid;

    logic [XW-1:0] countX, testTimeX, periodX, mrstStartX;
    logic [XW-1:0] saveAtX, mrstEndX, periodP1X;

    assign countX     = {1'b0, count};
    assign testTimeX  = {1'b0, testTime};
    assign periodX    = {1'b0, period};
    assign mrstStartX = {1'b0, mrstStart};
    assign saveAtX    = testTimeX + XW'(SAVE_OFFSET);
    assign mrstEndX   = mrstStartX + XW'(MRST_LEN);
    assign periodP1X  = periodX + XW'(1);

    assign cfgValid = (testTime != '0) && (saveAtX <= periodX) &&
                      (testTimeX < mrstStartX) && (mrstEndX <= periodP1X);

`ifndef STOP_CHAN_MASK_EN
    assign mask = 4'hF;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    always_comb begin
        stateNext  = state;
        countNext  = count;
        shotDone   = 1'b0;
        badTrig    = 1'b0;
        busy       = (state != IDLE);
        stop_dis   = '0;
        data_save  = 1'b0;
        master_rst = 1'b0;

        case (state)
            IDLE: begin
                if (tstart_tri) begin
                    if (cfgValid) begin
                        stateNext = MEAS;
                        countNext = CNT_W'(1);
                    end else begin
                        badTrig = 1'b1;
                    end
                end
            end
            MEAS: begin
                countNext = count + CNT_W'(1);
                if (count == testTime) stateNext = BLANK;
            end
            BLANK: begin
                if (count == period) begin
                    stateNext = IDLE;
                    countNext = '0;
                    shotDone  = 1'b1;
                end else begin
                    countNext = count + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase

        // Window decode is gated by busy so an idle-time register write
        // (e.g. mrst_start=0) cannot leak a pulse onto the TDC pins.
        if (busy) begin
            if ((countX > testTimeX) && (countX <= periodX)) stop_dis = mask;
            data_save  = (countX == saveAtX);
            master_rst = (countX >= mrstStartX) && (countX < mrstEndX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            testTime    <= CNT_W'(DEF_TEST_TIME);
            period      <= CNT_W'(DEF_PERIOD);
            mrstStart   <= CNT_W'(DEF_MRST_START);
            cfg_err     <= 1'b0;
            fifo_wrap   <= 1'b0;
            shot_cnt    <= '0;
            overrun_cnt <= '0;
`ifdef STOP_CHAN_MASK_EN
            mask        <= 4'hF;
`endif
        end else begin
            cfg_err   <= badTrig | (cfg_we & busy);
            fifo_wrap <= 1'b0;

            // Trigger validation above reads the registers before this
            // write lands, so a same-cycle write + trigger uses old values.
            if (cfg_we && !busy) begin
                case (cfg_addr)
                    2'd0: testTime  <= cfg_wdata;
                    2'd1: period    <= cfg_wdata;
                    2'd2: mrstStart <= cfg_wdata;
                    default: begin
`ifdef STOP_CHAN_MASK_EN
                        mask <= cfg_wdata[3:0];
`endif
                    end
                endcase
            end

            if (shotDone) begin
                if (shot_cnt == SHOT_LAST) begin
                    shot_cnt  <= '0;
                    fifo_wrap <= 1'b1;
                end else begin
                    shot_cnt <= shot_cnt + 13'd1;
                end
            end

            if (busy && tstart_tri && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// ----------------------------------------------------------------------------
// tb_tdc_meas_sequencer
//   Self-checking bench for tdc_meas_sequencer. A shot-level reference model
//   (position within the shot, register values, counters) predicts every
//   output each cycle; a vector table and hand sequences add fixed expected
//   values at the window boundaries.
// ----------------------------------------------------------------------------
module tb_tdc_meas_sequencer;

    // Shallow FIFO depth keeps the wrap test short.
    localparam int unsigned TB_FIFO_DEPTH = 16;

`ifdef STOP_CHAN_MASK_EN
    localparam logic [3:0] EXP_MASK = 4'b0101;
`else
    localparam logic [3:0] EXP_MASK = 4'hF;
`endif

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        tstart_tri;
    logic [3:0]  stop_dis;
    logic        master_rst;
    logic        data_save;
    logic        busy;
    logic        cfg_err;
    logic [12:0] shot_cnt;
    logic        fifo_wrap;
    logic [7:0]  overrun_cnt;

    tdc_meas_sequencer #(
        .FIFO_DEPTH(TB_FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .tstart_tri (tstart_tri),
        .stop_dis   (stop_dis),
        .master_rst (master_rst),
        .data_save  (data_save),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .shot_cnt   (shot_cnt),
        .fifo_wrap  (fifo_wrap),
        .overrun_cnt(overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;

    // ---------------- reference model ----------------
    bit         mAct;     // shot in progress
    longint     mK;       // cycle number within the shot (1..period)
    longint     mTt, mPer, mMrst;
    logic [3:0] mMask;
    int         mShot, mOvr;
    bit         mErr, mWrap;

    task automatic modelReset();
        mAct = 0; mK = 0;
        mTt = 15000; mPer = 20000; mMrst = 16000;
        mMask = 4'hF; mShot = 0; mOvr = 0; mErr = 0; mWrap = 0;
    endtask

    task automatic modelEdge();
        bit valid, e, w;
        if (reset) begin
            modelReset();
        end else begin
            e = 0; w = 0;
            valid = (mTt > 0) && (mTt + 100 <= mPer) && (mTt < mMrst) &&
                    (mMrst + 30 <= mPer + 1);
            if (cfg_we) begin
                if (mAct) e = 1;
                else begin
                    case (cfg_addr)
                        2'd0: mTt   = {32'd0, cfg_wdata};
                        2'd1: mPer  = {32'd0, cfg_wdata};
                        2'd2: mMrst = {32'd0, cfg_wdata};
                        default: begin
`ifdef STOP_CHAN_MASK_EN
                            mMask = cfg_wdata[3:0];
`endif
                        end
                    endcase
                end
            end
            if (mAct) begin
                if (tstart_tri && mOvr < 255) mOvr++;
                if (mK == mPer) begin
                    mAct = 0; mK = 0;
                    mShot = (mShot + 1) % TB_FIFO_DEPTH;
                    w = (mShot == 0);
                end else begin
                    mK++;
                end
            end else if (tstart_tri) begin
                if (valid) begin mAct = 1; mK = 1; end
                else e = 1;
            end
            mErr = e; mWrap = w;
        end
    endtask

    function automatic logic [3:0] expStop();
        return (mAct && mK > mTt && mK <= mPer) ? mMask : 4'h0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t, shot pos %0d)",
                     nm, act, exp, $time, mK);
        end
    endtask

    task automatic compareAll();
        chk("busy",        busy,        mAct);
        chk("stop_dis",    stop_dis,    expStop());
        chk("data_save",   data_save,   mAct && (mK == mTt + 100));
        chk("master_rst",  master_rst,  mAct && (mK >= mMrst) && (mK < mMrst + 30));
        chk("cfg_err",     cfg_err,     mErr);
        chk("fifo_wrap",   fifo_wrap,   mWrap);
        chk("shot_cnt",    shot_cnt,    mShot);
        chk("overrun_cnt", overrun_cnt, mOvr);
    endtask

    // One clock: DUT and model both take this edge, then compare off-edge.
    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic quiet();
        reset = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; tstart_tri = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        trig;
        logic        expBusy;
        logic        expErr;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int saveSeen, wraps, maxShot;
        errors = 0; checks = 0;
        modelReset();

        // test_time near the top of the range: test_time+100 only fails
        // the check when the sum is kept one bit wider.
        tbl[0]  = '{1'b1, 2'd0, 32'hFFFF_FFC0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 32'hFFFF_FFD0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 32'd0,         1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 2'd0, 32'd10,        1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'd1, 32'd50,        1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 2'd2, 32'd20,        1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 32'd0,         1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 2'd0, 32'd0,         1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'd3, 32'd5,         1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'd1, 32'd200,       1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 2'd2, 32'd50,        1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 32'd0,         1'b1, 1'b1, 1'b0};

        // Reset state
        quiet(); reset = 1;
        step(); step();
        reset = 0;
        chk("rst_busy", busy, 0);
        chk("rst_stop", stop_dis, 0);
        chk("rst_save", data_save, 0);
        chk("rst_mrst", master_rst, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_shot", shot_cnt, 0);
        chk("rst_ovr", overrun_cnt, 0);

        // Default timing shot
        tstart_tri = 1; step(); tstart_tri = 0;
        chk("dflt_busy_cyc1", busy, 1);
        saveSeen = 0;
        for (int i = 0; i < 20100 && mAct; i++) begin
            step();
            if (data_save) saveSeen++;
            case (mK)
                15000: chk("dflt_stop_15000", stop_dis, 4'h0);
                15001: chk("dflt_stop_15001", stop_dis, 4'hF);
                15099: chk("dflt_save_15099", data_save, 0);
                15100: chk("dflt_save_15100", data_save, 1);
                15999: chk("dflt_mrst_15999", master_rst, 0);
                16000: chk("dflt_mrst_16000", master_rst, 1);
                16029: chk("dflt_mrst_16029", master_rst, 1);
                16030: chk("dflt_mrst_16030", master_rst, 0);
                20000: chk("dflt_stop_20000", stop_dis, 4'hF);
                default: ;
            endcase
        end
        chk("dflt_idle_after", busy, 0);
        chk("dflt_save_once", saveSeen, 1);
        chk("dflt_shot_cnt", shot_cnt, 1);

        // Reset in the middle of a shot
        tstart_tri = 1; step(); tstart_tri = 0;
        for (int i = 0; i < 12500 && mK < 12000; i++) step();
        reset = 1; step(); reset = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_stop", stop_dis, 0);
        chk("midrst_mrst", master_rst, 0);
        chk("midrst_save", data_save, 0);
        chk("midrst_shot", shot_cnt, 0);

        // Config / validation vectors
        for (int i = 0; i < 13; i++) begin
            cfg_we = tbl[i].we; cfg_addr = tbl[i].addr;
            cfg_wdata = tbl[i].data; tstart_tri = tbl[i].trig;
            step();
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].expBusy);
            chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].expErr);
        end
        quiet();

        // Short shot (10/200/50) with triggers at counts 5, 100, 200
        for (int i = 0; i < 250 && mAct; i++) begin
            tstart_tri = (mK == 5 || mK == 100 || mK == 200);
            step();
            case (mK)
                10:  chk("short_stop_10", stop_dis, 4'h0);
                11:  chk("short_stop_11", stop_dis, EXP_MASK);
                50:  chk("short_mrst_50", master_rst, 1);
                79:  chk("short_mrst_79", master_rst, 1);
                80:  chk("short_mrst_80", master_rst, 0);
                110: chk("short_save_110", data_save, 1);
                200: chk("short_stop_200", stop_dis, EXP_MASK);
                default: ;
            endcase
        end
        tstart_tri = 0;
        chk("short_no_restart", busy, 0);
        chk("short_overruns", overrun_cnt, 3);
        chk("short_shot_cnt", shot_cnt, 1);
        step();
        chk("short_still_idle", busy, 0);

        // Write while busy is dropped
        tstart_tri = 1; step(); tstart_tri = 0;
        step(); step();
        wr(2'd0, 32'd77);
        chk("busy_wr_err", cfg_err, 1);
        step();
        chk("busy_wr_err_1cyc", cfg_err, 0);
        for (int i = 0; i < 250 && mAct; i++) step();
        tstart_tri = 1; step(); tstart_tri = 0;
        for (int i = 0; i < 20 && mK < 11; i++) step();
        chk("busy_wr_regs_kept", stop_dis, EXP_MASK);
        for (int i = 0; i < 250 && mAct; i++) step();

        // Back-to-back minimum shots across the shot counter wrap
        reset = 1; step(); reset = 0;
        wr(2'd0, 32'd1);
        wr(2'd1, 32'd101);
        wr(2'd2, 32'd72);
        tstart_tri = 1;
        wraps = 0; maxShot = 0;
        for (int i = 0; i < 16 * 102; i++) begin
            step();
            if (fifo_wrap) begin
                wraps++;
                chk("wrap_cnt_zero", shot_cnt, 0);
            end
            if (int'(shot_cnt) > maxShot) maxShot = int'(shot_cnt);
        end
        tstart_tri = 0;
        chk("wrap_once", wraps, 1);
        chk("wrap_max", maxShot, TB_FIFO_DEPTH - 1);
        chk("wrap_end_cnt", shot_cnt, 0);
        chk("ovr_saturated", overrun_cnt, 255);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 999) == 0);
            cfg_we     = ($urandom_range(0, 9) == 0);
            cfg_addr   = 2'($urandom_range(0, 3));
            case (cfg_addr)
                2'd0:    cfg_wdata = $urandom_range(0, 40);
                2'd1:    cfg_wdata = $urandom_range(60, 220);
                2'd2:    cfg_wdata = $urandom_range(1, 200);
                default: cfg_wdata = $urandom;
            endcase
            tstart_tri = ($urandom_range(0, 19) == 0);
            step();
        end
        quiet();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
